reg_file_dumper: RTL and testbench

Sequential read-out engine for the 32 x 32-bit CPU register file. On a start command it walks a contiguous index range through one asynchronous read port of the register file. It streams each word, tagged with its index, over a valid/ready handshake to a debug/trace consumer (UART bridge, testbench monitor). It owns only a read port and never writes the register file.

---
 rtl/cpu_pkg.sv | 13 +
 rtl/reg_file_dumper.sv | 93 +++++++++
 tb/tb_reg_file_dumper.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared CPU constants and register-file dumper state type
package cpu_pkg;

   localparam int XLEN      = 32;
   localparam int AW        = 5;
   localparam int REG_COUNT = 32;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } dump_state_t;

endpackage

// File: rtl/reg_file_dumper.sv
// rtl/reg_file_dumper.sv - streams a contiguous register-file index range over valid/ready
module reg_file_dumper
   import cpu_pkg::*;
(
   input  logic            clk,
   input  logic            rst,
   input  logic            start,
   input  logic [AW-1:0]   first,
   input  logic [AW-1:0]   last,
   input  logic            abort,
   output logic [AW-1:0]   rd_addr,
   input  logic [XLEN-1:0] rd_data,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] out_data,
   output logic [AW-1:0]   out_idx,
   output logic            out_last,
   output logic            busy,
   output logic            done
);

   dump_state_t   state;
   logic [AW-1:0] ptr;
   logic [AW-1:0] end_idx;
   logic          fetched_all;
   logic          load;
   logic          accept;

   // The read port follows the fetch pointer; busy is a direct decode of the state register.
   assign rd_addr = ptr;
   assign busy    = (state == RUN);

   // A new word may be captured when words remain and the output slot is empty or draining.
   assign load   = !fetched_all && (!out_valid || out_ready);
   assign accept = out_valid && out_ready;

   // Dump sequencer with inline output register; ptr stops at end_idx so it never wraps.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= IDLE;
         ptr         <= '0;
         end_idx     <= '0;
         fetched_all <= 1'b0;
         out_valid   <= 1'b0;
         out_data    <= '0;
         out_idx     <= '0;
         out_last    <= 1'b0;
         done        <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  if (first <= last) begin
                     ptr         <= first;
                     end_idx     <= last;
                     fetched_all <= 1'b0;
                     state       <= RUN;
                  end else begin
                     // Empty range: nothing to stream, report completion straight away.
                     done <= 1'b1;
                  end
               end
            end
            RUN: begin
               if (abort) begin
                  out_valid <= 1'b0;
                  state     <= IDLE;
               end else if (accept && out_last) begin
                  // The final word is only ever loaded once fetched_all is set, so no load here.
                  out_valid <= 1'b0;
                  state     <= IDLE;
                  done      <= 1'b1;
               end else if (load) begin
                  out_valid <= 1'b1;
                  out_data  <= rd_data;
                  out_idx   <= ptr;
                  out_last  <= (ptr == end_idx);
                  if (ptr == end_idx) begin
                     fetched_all <= 1'b1;
                  end else begin
                     ptr <= ptr + 1'b1;
                  end
               end else if (accept) begin
                  out_valid <= 1'b0;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_reg_file_dumper.sv
// tb/tb_reg_file_dumper.sv - directed self-checking bench for reg_file_dumper
module tb_reg_file_dumper;
   import cpu_pkg::*;

   logic            clk;
   logic            rst;
   logic            start;
   logic [AW-1:0]   first;
   logic [AW-1:0]   last;
   logic            abort;
   logic [AW-1:0]   rd_addr;
   logic [XLEN-1:0] rd_data;
   logic            out_valid;
   logic            out_ready;
   logic [XLEN-1:0] out_data;
   logic [AW-1:0]   out_idx;
   logic            out_last;
   logic            busy;
   logic            done;

   logic [XLEN-1:0] regs [REG_COUNT];

   int checks = 0;
   int errors = 0;

   reg_file_dumper dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .first     (first),
      .last      (last),
      .abort     (abort),
      .rd_addr   (rd_addr),
      .rd_data   (rd_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_idx   (out_idx),
      .out_last  (out_last),
      .busy      (busy),
      .done      (done)
   );

   assign rd_data = regs[rd_addr];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   function automatic logic [31:0] model(input int i);
      return (i == 0) ? 32'h0 : 32'h1000_0000 + i;
   endfunction

   initial begin
      int got;
      bit seen_done;
      bit pat [4];
      pat[0] = 1'b1; pat[1] = 1'b0; pat[2] = 1'b0; pat[3] = 1'b1;

      for (int i = 0; i < REG_COUNT; i++) regs[i] = model(i);

      rst = 1'b1; start = 1'b0; first = '0; last = '0; abort = 1'b0; out_ready = 1'b0;
      #12;
      chk("rst_out_valid", 32'(out_valid), 0);
      chk("rst_busy",      32'(busy), 0);
      chk("rst_done",      32'(done), 0);
      chk("rst_rd_addr",   32'(rd_addr), 0);
      chk("rst_out_data",  out_data, 0);
      chk("rst_out_idx",   32'(out_idx), 0);
      chk("rst_out_last",  32'(out_last), 0);
      @(negedge clk);
      rst = 1'b0;
      tick();

      // Full dump 0..31 with a start pulse in the middle that must be ignored.
      start = 1'b1; first = 5'd0; last = 5'd31; out_ready = 1'b1;
      tick();
      start = 1'b0;
      chk("full_busy", 32'(busy), 1);
      chk("full_rd_addr_first", 32'(rd_addr), 0);
      chk("full_no_valid_yet", 32'(out_valid), 0);
      for (int i = 0; i < 32; i++) begin
         tick();
         start = (i == 5);
         first = 5'd2; last = 5'd3;
         chk("full_valid", 32'(out_valid), 1);
         chk("full_idx",   32'(out_idx), 32'(i));
         chk("full_data",  out_data, model(i));
         chk("full_last",  32'(out_last), (i == 31) ? 1 : 0);
      end
      start = 1'b0;
      tick();
      chk("full_done",     32'(done), 1);
      chk("full_busy_end", 32'(busy), 0);
      chk("full_valid_end", 32'(out_valid), 0);
      tick();
      chk("full_done_clr", 32'(done), 0);

      // Back-pressure on 4..7 with ready pattern 1,0,0,1 repeating.
      start = 1'b1; first = 5'd4; last = 5'd7; out_ready = 1'b0;
      tick();
      start = 1'b0;
      got = 0; seen_done = 1'b0;
      for (int c = 0; c < 40; c++) begin
         if (done) begin
            seen_done = 1'b1;
            break;
         end
         out_ready = pat[c % 4];
         if (out_valid) begin
            chk("bp_idx",  32'(out_idx), 32'(4 + got));
            chk("bp_data", out_data, model(4 + got));
            chk("bp_last", 32'(out_last), (got == 3) ? 1 : 0);
            if (out_ready) got++;
         end
         tick();
      end
      chk("bp_count", 32'(got), 4);
      chk("bp_done_seen", 32'(seen_done), 1);
      out_ready = 1'b1;
      tick();

      // Single-entry range at the top index: ptr must not wrap.
      start = 1'b1; first = 5'd31; last = 5'd31;
      tick();
      start = 1'b0;
      chk("top_rd_addr", 32'(rd_addr), 31);
      tick();
      chk("top_valid", 32'(out_valid), 1);
      chk("top_idx",   32'(out_idx), 31);
      chk("top_data",  out_data, model(31));
      chk("top_last",  32'(out_last), 1);
      chk("top_rd_addr_hold", 32'(rd_addr), 31);
      tick();
      chk("top_done",  32'(done), 1);
      chk("top_valid_end", 32'(out_valid), 0);
      chk("top_no_wrap", 32'(rd_addr), 31);

      // Empty range 9..3: only a done pulse.
      tick();
      start = 1'b1; first = 5'd9; last = 5'd3;
      tick();
      start = 1'b0;
      chk("empty_done",  32'(done), 1);
      chk("empty_busy",  32'(busy), 0);
      chk("empty_valid", 32'(out_valid), 0);
      tick();
      chk("empty_done_clr", 32'(done), 0);
      chk("empty_valid2", 32'(out_valid), 0);

      // Abort after the idx 10 beat of 8..20, then a fresh 0..1 dump.
      start = 1'b1; first = 5'd8; last = 5'd20;
      tick();
      start = 1'b0;
      tick(); tick(); tick();
      chk("abort_pre_idx", 32'(out_idx), 10);
      abort = 1'b1;
      tick();
      abort = 1'b0;
      chk("abort_valid", 32'(out_valid), 0);
      chk("abort_busy",  32'(busy), 0);
      chk("abort_done",  32'(done), 0);
      tick();
      chk("abort_done2", 32'(done), 0);
      start = 1'b1; first = 5'd0; last = 5'd1;
      tick();
      start = 1'b0;
      tick();
      chk("restart_idx0",  32'(out_idx), 0);
      chk("restart_data0", out_data, 32'h0);
      tick();
      chk("restart_idx1",  32'(out_idx), 1);
      chk("restart_data1", out_data, model(1));
      chk("restart_last1", 32'(out_last), 1);
      tick();
      chk("restart_done",  32'(done), 1);

      // Asynchronous reset in the middle of a dump.
      tick();
      start = 1'b1; first = 5'd0; last = 5'd31;
      tick();
      start = 1'b0;
      tick(); tick();
      chk("pre_rst_valid", 32'(out_valid), 1);
      #2 rst = 1'b1;
      #1;
      chk("arst_valid",   32'(out_valid), 0);
      chk("arst_busy",    32'(busy), 0);
      chk("arst_rd_addr", 32'(rd_addr), 0);
      chk("arst_idx",     32'(out_idx), 0);
      @(negedge clk);
      rst = 1'b0;
      tick();
      chk("post_rst_idle", 32'(busy), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
